// File: rtl/neptune_pkg.sv
// neptune_pkg: shared types and constants for the Neptune I fetch sequencer.
//   fetch_state_t    : fetch FSM state encoding (HALT/ADDR/READ/EXEC/JUMP)
//   WDT_CYCLES_DEF   : default READ-state timeout in cycles
//   WDT_W            : watchdog counter width, sized from the default timeout
//   RESET_STATE      : state entered on rst
package neptune_pkg;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_ADDR = 3'd1,
        ST_READ = 3'd2,
        ST_EXEC = 3'd3,
        ST_JUMP = 3'd4
    } fetch_state_t;

    localparam int WDT_CYCLES_DEF = 255;
    localparam int WDT_W          = $clog2(WDT_CYCLES_DEF + 1);

    localparam fetch_state_t RESET_STATE = ST_HALT;

endpackage

// File: rtl/neptune_fetch_wdt.sv
// neptune_fetch_wdt: loadable down-counter with a zero flag, used as the
// READ-state fetch watchdog.
//   clk, rst    : clock, synchronous active-high reset
//   load_i      : load load_val_i into the counter (has priority over dec_i)
//   load_val_i  : value loaded
//   dec_i       : decrement by one, saturating at zero
//   zero_o      : counter is zero
module neptune_fetch_wdt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/neptune_fetch_seq.sv
// neptune_fetch_seq: instruction-fetch sequencer for the Neptune I v3.0 core.
// Walks HALT -> ADDR -> READ -> EXEC (-> JUMP) and drives the PC/MAR/IR
// register strobes, the memory read request and the execute handshake.
//
// Optional feature: define NEPTUNE_FETCH_WDT_EN to build a READ-state
// watchdog; after WDT_CYCLES READ cycles without mem_rdy the sequencer sets
// the sticky fault flag and returns to HALT. Undefined: fault is tied to 0
// and READ waits indefinitely.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : pulse, leaves HALT (ignored elsewhere and while fault = 1)
//   halt_req    : stop at the next instruction boundary
//   mem_rdy     : memory read data valid (looked at only in READ)
//   exec_done   : execute unit finished (looked at only in EXEC)
//   exec_jump   : with exec_done, the instruction loads a new PC
//   pc_oe, mar_we, pc_we, pc_incr, mem_rd, ir_we : datapath strobes
//   exec_req    : instruction ready for the execute unit
//   halted      : sequencer idle in HALT
//   fault       : sticky fetch timeout
//   retired     : completed-instruction count, wraps
//   dbg_state_o : current FSM state, for observation only
//
// Execute handshake: exec_req is held high for the whole EXEC state; the
// instruction completes in the first cycle where exec_req and exec_done are
// both high, and exec_jump is sampled only in that cycle.
module neptune_fetch_seq
    import neptune_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WDT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             mem_rdy,
    input  logic             exec_done,
    input  logic             exec_jump,
    output logic             pc_oe,
    output logic             mar_we,
    output logic             pc_we,
    output logic             pc_incr,
    output logic             mem_rd,
    output logic             ir_we,
    output logic             exec_req,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output fetch_state_t     dbg_state_o
);

    fetch_state_t     state_q, state_d;
    logic             halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             wdt_expire;
    logic             fault_w;

`ifdef NEPTUNE_FETCH_WDT_EN
    logic fault_q;
    logic wdt_zero;

    // Loaded with WDT_CYCLES-1 in ADDR so that zero is reached in the last
    // permitted READ cycle; mem_rdy in that cycle still completes the fetch.
    neptune_fetch_wdt #(
        .W(WDT_W)
    ) u_wdt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == ST_ADDR),
        .load_val_i(WDT_W'(WDT_CYCLES - 1)),
        .dec_i     (state_q == ST_READ),
        .zero_o    (wdt_zero)
    );

    assign wdt_expire = (state_q == ST_READ) && wdt_zero && !mem_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (wdt_expire) begin
            fault_q <= 1'b1;
        end
    end

    assign fault_w = fault_q;
`else
    logic wdt_unused;
    assign wdt_unused = (WDT_CYCLES == 0);
    assign wdt_expire = 1'b0;
    assign fault_w    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_oe     = 1'b0;
        mar_we    = 1'b0;
        pc_we     = 1'b0;
        pc_incr   = 1'b0;
        mem_rd    = 1'b0;
        ir_we     = 1'b0;
        exec_req  = 1'b0;
        halted    = 1'b0;
        retired_d = retired_q;

        case (state_q)
            ST_HALT: begin
                halted = 1'b1;
                if (start && !fault_w) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                pc_oe   = 1'b1;
                mar_we  = 1'b1;
                state_d = ST_READ;
            end
            ST_READ: begin
                mem_rd = 1'b1;
                if (wdt_expire) begin
                    state_d = ST_HALT;
                end else if (mem_rdy) begin
                    // IR load and PC increment happen in the data-valid cycle.
                    ir_we   = 1'b1;
                    pc_incr = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec_req = 1'b1;
                if (exec_done) begin
                    retired_d = retired_q + CNT_W'(1);
                    if (exec_jump) begin
                        state_d = ST_JUMP;
                    end else if (halt_pend_q || halt_req) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_JUMP: begin
                pc_we   = 1'b1;
                state_d = (halt_pend_q || halt_req) ? ST_HALT : ST_ADDR;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        // A halt request is remembered until the sequencer actually parks.
        if (state_d == ST_HALT) begin
            halt_pend_d = 1'b0;
        end else if ((state_q != ST_HALT) && halt_req) begin
            halt_pend_d = 1'b1;
        end else begin
            halt_pend_d = halt_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            halt_pend_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            retired_q   <= retired_d;
        end
    end

    assign fault       = fault_w;
    assign retired     = retired_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_neptune_fetch_seq.sv
// Directed-plus-random bench for neptune_fetch_seq. Each instruction is
// described as a transaction (read delay, execute delay, jump, halt request);
// the expected per-cycle strobe pattern and retired count follow from that.
module tb_neptune_fetch_seq;
    import neptune_pkg::*;

    localparam int CNT_W = 4;
    localparam int WDT   = 4;
`ifdef NEPTUNE_FETCH_WDT_EN
    localparam int RD_MAX  = WDT - 1;
    localparam int RD_LONG = WDT - 1;
`else
    localparam int RD_MAX  = 8;
    localparam int RD_LONG = 5;
`endif

    // Observation vector bit positions.
    localparam logic [8:0] E_PC_OE    = 9'h100;
    localparam logic [8:0] E_MAR_WE   = 9'h080;
    localparam logic [8:0] E_PC_WE    = 9'h040;
    localparam logic [8:0] E_PC_INCR  = 9'h020;
    localparam logic [8:0] E_MEM_RD   = 9'h010;
    localparam logic [8:0] E_IR_WE    = 9'h008;
    localparam logic [8:0] E_EXEC_REQ = 9'h004;
    localparam logic [8:0] E_HALTED   = 9'h002;
    localparam logic [8:0] E_FAULT    = 9'h001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, halt_req = 1'b0, mem_rdy = 1'b0;
    logic exec_done = 1'b0, exec_jump = 1'b0;
    logic pc_oe, mar_we, pc_we, pc_incr, mem_rd, ir_we, exec_req, halted, fault;
    logic [CNT_W-1:0] retired;
    fetch_state_t dbg_state;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model state.
    int  exp_retired = 0;
    bit  exp_fault   = 1'b0;
    bit  idle        = 1'b1;
    bit  pend        = 1'b0;

    logic [CNT_W+8:0] exp_q[$];

    neptune_fetch_seq #(
        .CNT_W     (CNT_W),
        .WDT_CYCLES(WDT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt_req   (halt_req),
        .mem_rdy    (mem_rdy),
        .exec_done  (exec_done),
        .exec_jump  (exec_jump),
        .pc_oe      (pc_oe),
        .mar_we     (mar_we),
        .pc_we      (pc_we),
        .pc_incr    (pc_incr),
        .mem_rd     (mem_rd),
        .ir_we      (ir_we),
        .exec_req   (exec_req),
        .halted     (halted),
        .fault      (fault),
        .retired    (retired),
        .dbg_state_o(dbg_state)
    );

    // Clock/reset block.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    function automatic bit nz();
        return 1'($urandom_range(0, 1));
    endfunction

    // One cycle: apply inputs after the edge, check outputs mid-cycle.
    task automatic step(input bit r, input bit s, input bit h, input bit m,
                        input bit d, input bit j, input logic [8:0] ev,
                        input string tag);
        logic [CNT_W+8:0] obs;
        logic [CNT_W+8:0] exp_v;
        @(posedge clk);
        #1;
        rst = r; start = s; halt_req = h; mem_rdy = m; exec_done = d; exec_jump = j;
        @(negedge clk);
        exp_v = {ev | (exp_fault ? E_FAULT : 9'h000), CNT_W'(exp_retired % 16)};
        exp_q.push_back(exp_v);
        obs = {pc_oe, mar_we, pc_we, pc_incr, mem_rd, ir_we, exec_req, halted, fault, retired};
        total_cnt++;
        assert (obs === exp_q.pop_front()) pass_cnt++;
        else $error("FAIL %s: observed strobes/retired=%h expected=%h", tag, obs, exp_v);
    endtask

    // One complete instruction, starting from HALT (idle) or ADDR.
    task automatic run_instr(input int rd_dly, input int ex_dly, input bit jmp, input bit hreq);
        bit done;
        if (idle) begin
            // halt_req alongside start must be ignored: start wins.
            step(0, 1, nz(), nz(), nz(), nz(), E_HALTED, "halt_start");
            idle = 1'b0;
        end
        step(0, nz(), 0, nz(), nz(), nz(), E_PC_OE | E_MAR_WE, "addr");
        for (int i = 0; i <= rd_dly; i++) begin
            step(0, nz(), hreq && (i == 0), i == rd_dly, nz(), nz(),
                 E_MEM_RD | ((i == rd_dly) ? (E_IR_WE | E_PC_INCR) : 9'h000), "read");
            if (hreq) pend = 1'b1;
        end
        for (int i = 0; i <= ex_dly; i++) begin
            done = (i == ex_dly);
            step(0, nz(), 0, nz(), done, done ? jmp : nz(), E_EXEC_REQ, "exec");
            if (done) exp_retired = (exp_retired + 1) % 16;
        end
        if (jmp) step(0, nz(), 0, nz(), nz(), nz(), E_PC_WE, "jump");
        if (pend) begin
            idle = 1'b1;
            pend = 1'b0;
        end
    endtask

    initial begin
        // Reset state.
        step(1, 0, 0, 0, 0, 0, E_HALTED, "reset");
        step(0, 0, 1, 1, 1, 1, E_HALTED, "halt_idle_ignores");
        step(0, 0, 0, 0, 0, 0, E_HALTED, "halt_idle");

        // Basic fetch: mem_rdy immediately, exec_done two cycles after exec_req.
        run_instr(0, 2, 0, 0);
        // Delayed memory.
        run_instr(RD_LONG, 0, 0, 0);
        // Jump.
        run_instr(1, 1, 1, 0);
        // Halt request during READ: instruction completes, then park.
        run_instr(2, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0, E_HALTED, "parked");
        // Jump with halt request: JUMP completes, then park.
        run_instr(0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, E_HALTED, "parked_after_jump");

        // Reset during EXEC with exec_req high; late exec_done ignored.
        step(0, 1, 0, 0, 0, 0, E_HALTED, "rst_pre_start");
        step(0, 0, 0, 0, 0, 0, E_PC_OE | E_MAR_WE, "rst_pre_addr");
        step(0, 0, 0, 1, 0, 0, E_MEM_RD | E_IR_WE | E_PC_INCR, "rst_pre_read");
        step(0, 0, 0, 0, 0, 0, E_EXEC_REQ, "rst_pre_exec");
        step(1, 0, 0, 0, 0, 0, E_EXEC_REQ, "rst_assert_exec");
        exp_retired = 0;
        idle = 1'b1;
        pend = 1'b0;
        step(0, 0, 0, 0, 1, 1, E_HALTED, "rst_late_done");
        step(0, 0, 0, 0, 0, 0, E_HALTED, "rst_after");

        // Random instructions; more than 16 so retired wraps 15 -> 0.
        for (int n = 0; n < 24; n++) begin
            run_instr($urandom_range(0, RD_MAX), $urandom_range(0, 3),
                      nz(), $urandom_range(0, 4) == 0);
        end

`ifdef NEPTUNE_FETCH_WDT_EN
        // Watchdog: mem_rdy never arrives.
        if (idle) begin
            step(0, 1, 0, 0, 0, 0, E_HALTED, "wdt_start");
            idle = 1'b0;
        end
        step(0, 0, 0, 0, 0, 0, E_PC_OE | E_MAR_WE, "wdt_addr");
        for (int i = 0; i < WDT; i++) begin
            step(0, 0, 0, 0, 0, 0, E_MEM_RD, "wdt_read");
        end
        exp_fault = 1'b1;
        idle = 1'b1;
        step(0, 1, 0, 1, 0, 0, E_HALTED, "wdt_fault_halt");
        step(0, 1, 0, 1, 0, 0, E_HALTED, "wdt_start_ignored");
        step(1, 0, 0, 0, 0, 0, E_HALTED, "wdt_rst");
        exp_fault   = 1'b0;
        exp_retired = 0;
        step(0, 0, 0, 0, 0, 0, E_HALTED, "wdt_cleared");
        run_instr(0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/neptune_fetch_seq.md
Name: neptune_fetch_seq

Overview:
- Instruction-fetch sequencer for the Neptune I v3.0 core.
- Drives the PC and MAR register control strobes (pc_we, pc_incr, mar_we), the memory read request and the IR load.
- Hands each fetched instruction to the execute unit over a req/done handshake.
- Sits between the top-level control unit and the PC/MAR/IR datapath registers.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- WDT_CYCLES, 255: maximum READ-state cycles before a fetch fault (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins fetching from HALT
- halt_req  in  1  request to stop at the next instruction boundary
- mem_rdy  in  1  memory read data valid
- exec_done  in  1  execute unit finished the current instruction
- exec_jump  in  1  qualified by exec_done; instruction loads a new PC
- pc_oe  out  1  drive PC onto the A bus
- mar_we  out  1  MAR write enable
- pc_we  out  1  PC write enable (jump target from bus)
- pc_incr  out  1  PC increment
- mem_rd  out  1  memory read request
- ir_we  out  1  instruction register write enable
- exec_req  out  1  instruction ready for execute unit
- halted  out  1  sequencer idle in HALT
- fault  out  1  sticky fetch timeout (optional feature)
- retired  out  CNT_W  instructions completed

Behaviour:
- States: HALT (reset state), ADDR, READ, EXEC, JUMP.
- Reset: state = HALT, halted = 1, every strobe = 0, retired = 0, halt_pending = 0, fault = 0. Reset takes effect at the next clk edge from any state, including mid-handshake.
- HALT:
  - halted = 1, all strobes 0.
  - start = 1 moves to ADDR next cycle.
  - halt_req is ignored in HALT; start wins if both are asserted.
- ADDR: pc_oe = 1 and mar_we = 1 for exactly 1 cycle, then READ.
- READ:
  - mem_rd = 1 held every cycle until mem_rdy.
  - In the cycle mem_rdy = 1, ir_we = 1 and pc_incr = 1 (Mealy, same cycle), then EXEC.
  - Minimum fetch latency is 3 cycles from start to exec_req (HALT, ADDR, READ with mem_rdy in its first cycle).
- EXEC:
  - exec_req = 1 held until exec_done.
  - On exec_done, retired increments by 1. It wraps from all-ones to 0.
  - Next state: exec_jump = 1 goes to JUMP; otherwise halt_pending or halt_req goes to HALT; otherwise ADDR.
- JUMP:
  - pc_we = 1 for 1 cycle.
  - Then HALT if halt_pending, else ADDR.
- halt_pending:
  - Set on halt_req in any non-HALT state.
  - Cleared on entry to HALT.
  - The instruction in flight always completes, including its jump.
- Mutual exclusion: pc_we and pc_incr are never asserted in the same cycle, and neither is asserted outside READ/JUMP.
- start in any non-HALT state is ignored.
- mem_rdy outside READ, and exec_done outside EXEC, are ignored.

Optional Feature:
- Macro: NEPTUNE_FETCH_WDT_EN.
- Defined:
  - A READ-cycle counter (width covers WDT_CYCLES) clears on ADDR.
  - If mem_rdy has not arrived after WDT_CYCLES cycles in READ, the sequencer sets fault = 1 and goes to HALT without asserting ir_we or pc_incr.
  - fault is sticky until rst.
  - start is ignored while fault = 1.
- Undefined:
  - No counter is built and fault is tied to 0.
  - READ waits indefinitely.

Decomposition:
- neptune_pkg holds:
  - the state encoding typedef (HALT/ADDR/READ/EXEC/JUMP);
  - the WDT counter width derived from the default WDT_CYCLES;
  - a reset-state constant.
- One sub-module, neptune_fetch_wdt: loadable down-counter with a timeout flag, instantiated only under NEPTUNE_FETCH_WDT_EN.

Test Plan:
- Reset, then start pulse, mem_rdy in the first READ cycle, exec_done 2 cycles after exec_req, exec_jump = 0 -> strobe sequence pc_oe/mar_we (cycle 1), mem_rd+ir_we+pc_incr (cycle 2), exec_req (cycles 3-5); retired = 1; back in ADDR.
- mem_rdy delayed 5 cycles -> mem_rd high for 6 cycles; ir_we and pc_incr high only in the 6th; no PC/MAR strobes during the wait.
- exec_done with exec_jump = 1 -> exactly one pc_we cycle, pc_incr not asserted in that cycle, then ADDR.
- halt_req pulse during READ -> the instruction completes and retired increments; on exec_done the sequencer goes to HALT and halted = 1; a following start resumes at ADDR.
- Reset asserted during EXEC with exec_req high -> next cycle halted = 1, exec_req = 0, retired = 0; a late exec_done is ignored.
- Retired counter preloaded near wrap (CNT_W = 4, run 16 instructions) -> retired wraps 15 -> 0.
- With NEPTUNE_FETCH_WDT_EN and WDT_CYCLES = 4, mem_rdy never asserted -> fault = 1 after 4 READ cycles, sequencer in HALT, ir_we never asserted, start ignored until rst.
